// File: rtl/complex_mult_sequencer.sv
// complex_mult_sequencer
//   Computes one complex product (re1 + j*im1) * (re2 + j*im2), or with the conjugate of
//   operand 2 when op_i=1. It time-shares one pipelined float multiplier and one pipelined
//   float adder/subtractor. All arithmetic happens in those cores; this block only sequences
//   operands and captures results. Every output is registered.
//
// Ports
//   clk_i, rst_i            clock (rising edge), synchronous active-high reset
//   start_i, op_i           request (sampled only in idle) and conjugate select
//   re1_i, im1_i            operand 1, IEEE-754 single; latched with start_i
//   re2_i, im2_i            operand 2, IEEE-754 single; latched with start_i
//   re_o, im_o              result, held from ready_o until the next ready_o
//   ready_o                 one-cycle pulse: re_o/im_o are valid
//   busy_o                  high in every state except idle
//   mul_a_o, mul_b_o        multiplier operands
//   mul_nd_o                multiplier new-data strobe
//   mul_res_i, mul_rdy_i    multiplier result and valid
//   add_a_o, add_b_o        adder operands
//   add_sub_o               1: add_a_o - add_b_o, 0: add_a_o + add_b_o
//   add_nd_o                adder new-data strobe
//   add_res_i, add_rdy_i    adder result and valid
module complex_mult_sequencer #(
  parameter int unsigned MUL_LAT   = 6,
  parameter int unsigned ADD_LAT   = 8,
  parameter int unsigned FLUSH_LEN = 9
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        op_i,
  input  logic [31:0] re1_i,
  input  logic [31:0] im1_i,
  input  logic [31:0] re2_i,
  input  logic [31:0] im2_i,
  output logic [31:0] re_o,
  output logic [31:0] im_o,
  output logic        ready_o,
  output logic        busy_o,
  output logic [31:0] mul_a_o,
  output logic [31:0] mul_b_o,
  output logic        mul_nd_o,
  input  logic [31:0] mul_res_i,
  input  logic        mul_rdy_i,
  output logic [31:0] add_a_o,
  output logic [31:0] add_b_o,
  output logic        add_sub_o,
  output logic        add_nd_o,
  input  logic [31:0] add_res_i,
  input  logic        add_rdy_i
);

  // The drain must outlast the longest core pipeline so nothing issued before reset survives.
  localparam int unsigned MaxLat      = (MUL_LAT > ADD_LAT) ? MUL_LAT : ADD_LAT;
  localparam int unsigned FlushCycles = (FLUSH_LEN > MaxLat) ? FLUSH_LEN : MaxLat + 1;
  localparam int unsigned CntW        = $clog2(FlushCycles + 1);
  localparam logic [CntW-1:0] FlushLast = CntW'(FlushCycles - 1);
  localparam logic [CntW-1:0] CntThree  = CntW'(3);

  typedef enum logic [2:0] {
    StFlush, StIdle, StMulIss, StMulWait, StAddIss, StAddWait, StDone
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic            op_q, op_d;
  logic [31:0]     re1_q, re1_d, im1_q, im1_d, re2_q, re2_d, im2_q, im2_d;
  logic [31:0]     p_q [4];
  logic [31:0]     p_d [4];
  logic [31:0]     re_q, re_d, im_q, im_d;
  logic            ready_q, ready_d, busy_q, busy_d;
  logic [31:0]     mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic            mul_nd_q, mul_nd_d;
  logic [31:0]     add_a_q, add_a_d, add_b_q, add_b_d;
  logic            add_sub_q, add_sub_d, add_nd_q, add_nd_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    op_d      = op_q;
    re1_d     = re1_q;
    im1_d     = im1_q;
    re2_d     = re2_q;
    im2_d     = im2_q;
    p_d       = p_q;
    re_d      = re_q;
    im_d      = im_q;
    ready_d   = 1'b0;
    mul_a_d   = mul_a_q;
    mul_b_d   = mul_b_q;
    mul_nd_d  = 1'b0;
    add_a_d   = add_a_q;
    add_b_d   = add_b_q;
    add_sub_d = add_sub_q;
    add_nd_d  = 1'b0;

    unique case (state_q)
      StFlush: begin
        if (cnt_q == FlushLast) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StIdle: begin
        if (start_i) begin
          state_d  = StMulIss;
          cnt_d    = '0;
          op_d     = op_i;
          re1_d    = re1_i;
          im1_d    = im1_i;
          re2_d    = re2_i;
          im2_d    = im2_i;
          // P0 = re1*re2 goes out straight from the inputs being latched.
          mul_nd_d = 1'b1;
          mul_a_d  = re1_i;
          mul_b_d  = re2_i;
        end
      end
      StMulIss: begin
        // cnt_q counts issues already on the bus; this sets up the next one.
        if (cnt_q == CntThree) begin
          state_d = StMulWait;
          cnt_d   = '0;
        end else begin
          mul_nd_d = 1'b1;
          cnt_d    = cnt_q + CntW'(1);
          unique case (cnt_q[1:0])
            2'd0:    begin mul_a_d = im1_q; mul_b_d = im2_q; end  // P1
            2'd1:    begin mul_a_d = re1_q; mul_b_d = im2_q; end  // P2
            default: begin mul_a_d = im1_q; mul_b_d = re2_q; end  // P3
          endcase
        end
      end
      StMulWait: begin
        if (mul_rdy_i) begin
          p_d[idx_q] = mul_res_i;
          idx_d      = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            // Real part only needs P0/P1, which are already stored.
            state_d   = StAddIss;
            cnt_d     = '0;
            add_nd_d  = 1'b1;
            add_a_d   = p_q[0];
            add_b_d   = p_q[1];
            add_sub_d = ~op_q;
          end
        end
      end
      StAddIss: begin
        if (cnt_q == '0) begin
          cnt_d    = CntW'(1);
          add_nd_d = 1'b1;
          if (op_q) begin
            add_a_d   = p_q[3];
            add_b_d   = p_q[2];
            add_sub_d = 1'b1;
          end else begin
            add_a_d   = p_q[2];
            add_b_d   = p_q[3];
            add_sub_d = 1'b0;
          end
        end else begin
          state_d = StAddWait;
          cnt_d   = '0;
        end
      end
      StAddWait: begin
        if (add_rdy_i) begin
          if (!idx_q[0]) begin
            // Park the real part in P0 so re_o/im_o only change together on ready.
            p_d[0] = add_res_i;
            idx_d  = 2'd1;
          end else begin
            re_d    = p_q[0];
            im_d    = add_res_i;
            idx_d   = 2'd0;
            ready_d = 1'b1;
            state_d = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StFlush;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StFlush;
      cnt_q     <= '0;
      idx_q     <= '0;
      op_q      <= 1'b0;
      re1_q     <= '0;
      im1_q     <= '0;
      re2_q     <= '0;
      im2_q     <= '0;
      for (int i = 0; i < 4; i++) p_q[i] <= '0;
      re_q      <= '0;
      im_q      <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b1;
      mul_a_q   <= '0;
      mul_b_q   <= '0;
      mul_nd_q  <= 1'b0;
      add_a_q   <= '0;
      add_b_q   <= '0;
      add_sub_q <= 1'b0;
      add_nd_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      op_q      <= op_d;
      re1_q     <= re1_d;
      im1_q     <= im1_d;
      re2_q     <= re2_d;
      im2_q     <= im2_d;
      p_q       <= p_d;
      re_q      <= re_d;
      im_q      <= im_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      mul_a_q   <= mul_a_d;
      mul_b_q   <= mul_b_d;
      mul_nd_q  <= mul_nd_d;
      add_a_q   <= add_a_d;
      add_b_q   <= add_b_d;
      add_sub_q <= add_sub_d;
      add_nd_q  <= add_nd_d;
    end
  end

  assign re_o      = re_q;
  assign im_o      = im_q;
  assign ready_o   = ready_q;
  assign busy_o    = busy_q;
  assign mul_a_o   = mul_a_q;
  assign mul_b_o   = mul_b_q;
  assign mul_nd_o  = mul_nd_q;
  assign add_a_o   = add_a_q;
  assign add_b_o   = add_b_q;
  assign add_sub_o = add_sub_q;
  assign add_nd_o  = add_nd_q;

endmodule

// File: tb/tb_complex_mult_sequencer.sv
module tb_complex_mult_sequencer;
  localparam int unsigned MUL_LAT   = 6;
  localparam int unsigned ADD_LAT   = 8;
  localparam int unsigned FLUSH_LEN = 9;
  localparam int          OpLat     = 21;   // start edge to ready cycle with these latencies

  logic        clk = 1'b0;
  logic        rst, start, op;
  logic [31:0] re1, im1, re2, im2;
  logic [31:0] re, im, mul_a, mul_b, add_a, add_b;
  logic        ready, busy, mul_nd, add_nd, add_sub;
  logic [31:0] mul_res_m = '0, add_res_m = '0;
  logic        mul_rdy_m = 1'b0, add_rdy_m = 1'b0, stray_mul = 1'b0, stray_add = 1'b0;
  logic        mul_rdy, add_rdy;

  assign mul_rdy = mul_rdy_m | stray_mul;
  assign add_rdy = add_rdy_m | stray_add;

  complex_mult_sequencer #(
    .MUL_LAT(MUL_LAT), .ADD_LAT(ADD_LAT), .FLUSH_LEN(FLUSH_LEN)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .op_i(op),
    .re1_i(re1), .im1_i(im1), .re2_i(re2), .im2_i(im2),
    .re_o(re), .im_o(im), .ready_o(ready), .busy_o(busy),
    .mul_a_o(mul_a), .mul_b_o(mul_b), .mul_nd_o(mul_nd),
    .mul_res_i(mul_res_m), .mul_rdy_i(mul_rdy),
    .add_a_o(add_a), .add_b_o(add_b), .add_sub_o(add_sub), .add_nd_o(add_nd),
    .add_res_i(add_res_m), .add_rdy_i(add_rdy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Operands are small integers, so float values are exact and integer math models the cores.
  function automatic logic [31:0] int_to_f32(input int v);
    int unsigned m;
    int          e;
    logic [31:0] r;
    if (v == 0) return 32'h0;
    m = (v < 0) ? int'(-v) : v;
    e = 0;
    for (int i = 0; i < 32; i++) if (m[i]) e = i;
    r[31]    = (v < 0);
    r[30:23] = 8'(127 + e);
    r[22:0]  = 23'((m << (23 - e)) & 32'h007F_FFFF);
    return r;
  endfunction

  function automatic int f32_to_int(input logic [31:0] b);
    int          e;
    int unsigned m;
    int          v;
    if (b[30:0] == 31'h0) return 0;
    e = int'(b[30:23]) - 127;
    if (e < 0 || e > 23) return 0;
    m = {9'd1, b[22:0]};
    v = int'(m >> (23 - e));
    return b[31] ? -v : v;
  endfunction

  function automatic int rnd();
    return int'($urandom_range(200)) - 100;
  endfunction

  // Reference: complex product from first principles.
  function automatic void cref(input bit o, input int a, input int b, input int c, input int d,
                               output logic [31:0] er, output logic [31:0] ei);
    int r, i;
    if (!o) begin r = a * c - b * d; i = a * d + b * c; end
    else    begin r = a * c + b * d; i = b * c - a * d; end
    er = int_to_f32(r);
    ei = int_to_f32(i);
  endfunction

  // Core models: exact pipelines, result and rdy appear LAT cycles after nd.
  int mv [MUL_LAT+1];
  bit mn [MUL_LAT+1];
  int av [ADD_LAT+1];
  bit an [ADD_LAT+1];
  always @(negedge clk) begin
    for (int i = MUL_LAT; i > 0; i--) begin mv[i] = mv[i-1]; mn[i] = mn[i-1]; end
    mn[0] = mul_nd;
    mv[0] = f32_to_int(mul_a) * f32_to_int(mul_b);
    mul_rdy_m = mn[MUL_LAT];
    mul_res_m = int_to_f32(mv[MUL_LAT]);
    for (int i = ADD_LAT; i > 0; i--) begin av[i] = av[i-1]; an[i] = an[i-1]; end
    an[0] = add_nd;
    av[0] = add_sub ? f32_to_int(add_a) - f32_to_int(add_b)
                    : f32_to_int(add_a) + f32_to_int(add_b);
    add_rdy_m = an[ADD_LAT];
    add_res_m = int_to_f32(av[ADD_LAT]);
  end

  always @(posedge clk) cyc <= cyc + 1;

  int          rdy_cyc [$];
  logic [31:0] rdy_re [$];
  logic [31:0] rdy_im [$];
  int          mnd_cyc [$];
  int          and_cyc [$];
  always @(posedge clk) begin
    #1;
    if (ready) begin rdy_cyc.push_back(cyc); rdy_re.push_back(re); rdy_im.push_back(im); end
    if (mul_nd) mnd_cyc.push_back(cyc);
    if (add_nd) and_cyc.push_back(cyc);
  end

  task automatic clear_log();
    rdy_cyc.delete(); rdy_re.delete(); rdy_im.delete(); mnd_cyc.delete(); and_cyc.delete();
  endtask

  task automatic set_ops(input bit o, input int a, input int b, input int c, input int d);
    op = o; re1 = int_to_f32(a); im1 = int_to_f32(b); re2 = int_to_f32(c); im2 = int_to_f32(d);
  endtask

  // Returns at the negedge of cycle 1; s is the cycle count of cycle 0.
  task automatic do_start(input bit o, input int a, input int b, input int c, input int d,
                          output int s);
    @(negedge clk);
    set_ops(o, a, b, c, d);
    start = 1'b1;
    s = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_ready(input int n, input int budget);
    int k = 0;
    while (rdy_cyc.size() <= n && k < budget) begin @(negedge clk); k++; end
    if (rdy_cyc.size() <= n) begin
      n_checks++; n_fail++;
      $display("FAIL wait_ready: no ready within %0d cycles (seen %0d)", budget, rdy_cyc.size());
    end
  endtask

  task automatic test_reset();
    clear_log();
    @(negedge clk); rst = 1'b1; start = 1'b1;
    @(negedge clk); rst = 1'b0;
    n_checks += 4;
    if (ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b want 0", ready); end
    if (re !== 32'h0 || im !== 32'h0) begin
      n_fail++; $display("FAIL rst_result: got %h/%h want 0/0", re, im);
    end
    if (mul_nd !== 1'b0 || add_nd !== 1'b0) begin
      n_fail++; $display("FAIL rst_nd: got %b/%b want 0/0", mul_nd, add_nd);
    end
    if (mul_a !== 32'h0 || add_b !== 32'h0 || add_sub !== 1'b0) begin
      n_fail++; $display("FAIL rst_operands: got %h %h %b want 0", mul_a, add_b, add_sub);
    end
    for (int k = 1; k <= 9; k++) begin
      n_checks++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL flush_busy[%0d]: got %b want 1", k, busy); end
      @(negedge clk);
    end
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_end: busy got %b want 0", busy); end
    repeat (5) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || mnd_cyc.size() != 0) begin
      n_fail++; $display("FAIL flush_start_ignored: busy %b mul_nd count %0d want 0/0",
                         busy, mnd_cyc.size());
    end
  endtask

  task automatic test_fixed(input bit o, input logic [31:0] want_re, input logic [31:0] want_im);
    int s;
    logic [31:0] er, ei;
    clear_log();
    cref(o, 1, 2, 3, 4, er, ei);
    do_start(o, 1, 2, 3, 4, s);
    wait_ready(0, 40);
    repeat (3) @(negedge clk);
    n_checks += 5;
    if (rdy_cyc.size() != 1) begin
      n_fail++; $display("FAIL fixed_op%0d_count: got %0d pulses want 1", o, rdy_cyc.size());
    end
    if (rdy_cyc.size() > 0) begin
      if (rdy_cyc[0] - s != OpLat) begin
        n_fail++; $display("FAIL fixed_op%0d_latency: got %0d want %0d", o, rdy_cyc[0] - s, OpLat);
      end
      if (rdy_re[0] !== want_re || rdy_re[0] !== er) begin
        n_fail++; $display("FAIL fixed_op%0d_re: got %h want %h", o, rdy_re[0], want_re);
      end
      if (rdy_im[0] !== want_im || rdy_im[0] !== ei) begin
        n_fail++; $display("FAIL fixed_op%0d_im: got %h want %h", o, rdy_im[0], want_im);
      end
    end
    if (re !== want_re) begin n_fail++; $display("FAIL fixed_op%0d_hold: got %h want %h", o, re, want_re); end
    n_checks += 2;
    if (mnd_cyc.size() != 4 || mnd_cyc[0] - s != 1 || mnd_cyc[3] - s != 4) begin
      n_fail++; $display("FAIL fixed_op%0d_mul_nd: count %0d want 4 in cycles 1-4", o, mnd_cyc.size());
    end
    if (and_cyc.size() != 2 || and_cyc[0] - s != 5 + MUL_LAT || and_cyc[1] - s != 6 + MUL_LAT) begin
      n_fail++; $display("FAIL fixed_op%0d_add_nd: count %0d want 2 in cycles 11-12", o, and_cyc.size());
    end
  endtask

  task automatic test_back_to_back();
    int s, a[4], b[4];
    bit oa, ob;
    logic [31:0] ear, eai, ebr, ebi;
    clear_log();
    oa = 1'($urandom_range(1)); ob = 1'($urandom_range(1));
    for (int i = 0; i < 4; i++) begin a[i] = rnd(); b[i] = rnd(); end
    cref(oa, a[0], a[1], a[2], a[3], ear, eai);
    cref(ob, b[0], b[1], b[2], b[3], ebr, ebi);
    @(negedge clk);
    set_ops(oa, a[0], a[1], a[2], a[3]);
    start = 1'b1;
    s = cyc;
    for (int i = 1; i <= OpLat; i++) begin
      @(negedge clk);
      set_ops(1'($urandom_range(1)), rnd(), rnd(), rnd(), rnd());
    end
    @(negedge clk);
    set_ops(ob, b[0], b[1], b[2], b[3]);
    @(negedge clk);
    start = 1'b0;
    wait_ready(1, 40);
    repeat (30) @(negedge clk);
    n_checks++;
    if (rdy_cyc.size() != 2) begin
      n_fail++; $display("FAIL b2b_count: got %0d results want 2", rdy_cyc.size());
    end
    if (rdy_cyc.size() >= 2) begin
      n_checks += 6;
      if (rdy_cyc[0] - s != OpLat) begin
        n_fail++; $display("FAIL b2b_first_latency: got %0d want %0d", rdy_cyc[0] - s, OpLat);
      end
      if (rdy_cyc[1] - rdy_cyc[0] != 22) begin
        n_fail++; $display("FAIL b2b_spacing: got %0d want 22", rdy_cyc[1] - rdy_cyc[0]);
      end
      if (rdy_re[0] !== ear) begin n_fail++; $display("FAIL b2b_a_re: got %h want %h", rdy_re[0], ear); end
      if (rdy_im[0] !== eai) begin n_fail++; $display("FAIL b2b_a_im: got %h want %h", rdy_im[0], eai); end
      if (rdy_re[1] !== ebr) begin n_fail++; $display("FAIL b2b_b_re: got %h want %h", rdy_re[1], ebr); end
      if (rdy_im[1] !== ebi) begin n_fail++; $display("FAIL b2b_b_im: got %h want %h", rdy_im[1], ebi); end
    end
  endtask

  task automatic test_op(input string name, input int budget_gap);
    int s, v[4];
    bit o;
    logic [31:0] er, ei;
    clear_log();
    o = 1'($urandom_range(1));
    for (int i = 0; i < 4; i++) v[i] = rnd();
    cref(o, v[0], v[1], v[2], v[3], er, ei);
    do_start(o, v[0], v[1], v[2], v[3], s);
    wait_ready(0, 40);
    n_checks += 4;
    if (rdy_cyc.size() != 1) begin
      n_fail++; $display("FAIL %s_count: got %0d want 1", name, rdy_cyc.size());
    end
    if (rdy_cyc.size() > 0) begin
      if (rdy_cyc[0] - s != OpLat) begin
        n_fail++; $display("FAIL %s_latency: got %0d want %0d", name, rdy_cyc[0] - s, OpLat);
      end
      if (rdy_re[0] !== er) begin n_fail++; $display("FAIL %s_re: got %h want %h", name, rdy_re[0], er); end
      if (rdy_im[0] !== ei) begin n_fail++; $display("FAIL %s_im: got %h want %h", name, rdy_im[0], ei); end
    end
    repeat (budget_gap) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int s, k;
    clear_log();
    do_start(1'($urandom_range(1)), rnd(), rnd(), rnd(), rnd(), s);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks += 2;
    if (re !== 32'h0 || im !== 32'h0) begin
      n_fail++; $display("FAIL midrst_result: got %h/%h want 0/0", re, im);
    end
    if (busy !== 1'b1) begin n_fail++; $display("FAIL midrst_busy: got %b want 1", busy); end
    k = 0;
    while (busy === 1'b1 && k < 30) begin @(negedge clk); k++; end
    n_checks += 2;
    if (cyc - s != 20) begin
      n_fail++; $display("FAIL midrst_flush_len: idle at cycle %0d want 20", cyc - s);
    end
    repeat (10) @(negedge clk);
    if (rdy_cyc.size() != 0) begin
      n_fail++; $display("FAIL midrst_no_ready: got %0d pulses want 0", rdy_cyc.size());
    end
    test_op("midrst_after", 0);
  endtask

  task automatic test_stray();
    logic [31:0] sre, sim;
    clear_log();
    repeat (3) @(negedge clk);
    sre = re; sim = im;
    stray_mul = 1'b1;
    @(negedge clk); stray_mul = 1'b0; stray_add = 1'b1;
    @(negedge clk); stray_mul = 1'b1;
    @(negedge clk); stray_mul = 1'b0; stray_add = 1'b0;
    repeat (4) @(negedge clk);
    n_checks += 3;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL stray_busy: got %b want 0", busy); end
    if (re !== sre || im !== sim) begin
      n_fail++; $display("FAIL stray_result: got %h/%h want %h/%h", re, im, sre, sim);
    end
    if (rdy_cyc.size() != 0 || mnd_cyc.size() != 0 || and_cyc.size() != 0) begin
      n_fail++; $display("FAIL stray_activity: ready %0d mul_nd %0d add_nd %0d want 0",
                         rdy_cyc.size(), mnd_cyc.size(), and_cyc.size());
    end
    test_op("stray_after", 2);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    set_ops(1'b0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_fixed(1'b0, 32'hC0A0_0000, 32'h4120_0000);   // -5 + 10j
    test_fixed(1'b1, 32'h4130_0000, 32'h4000_0000);   // (1+2j)(3-4j) = 11 + 2j
    test_back_to_back();
    test_reset_mid();
    test_stray();
    for (int n = 0; n < 6; n++) test_op("random", int'($urandom_range(3)));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
